// File: rtl/decode_issue_stage.sv
// IF/ID holding register plus ARM decoder with a pending-write scoreboard.
// Latency: accept on edge N, decode valid after N, earliest issue on edge N+1; holds on hazard or !issueReady.
module decode_issue_stage #(
    parameter int NUM_REGS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrIn,
    input  logic [31:0] pcIn,
    input  logic        instrValid,
    output logic        instrReady,
    input  logic        flush,
    input  logic        issueReady,
    output logic        issueValid,
    output logic [3:0]  readReg1,
    output logic [3:0]  readReg2,
    output logic [3:0]  writeDestination,
    output logic        writeEnable,
    output logic [3:0]  aluOp,
    output logic        useImm,
    output logic [31:0] imm,
    output logic        isLoad,
    output logic        isStore,
    output logic        isBranch,
    output logic [3:0]  condCode,
    output logic [31:0] pcOut,
    output logic        stall,
    input  logic        wbEnable,
    input  logic [3:0]  wbDest
);

    logic                held_valid;
    logic [31:0]         held_instr;
    logic [31:0]         held_pc;
    logic [NUM_REGS-1:0] pending;

    logic                writes;
    logic                use_rn;
    logic                use_rm;
    logic [31:0]         imm8_ext;
    logic [4:0]          rot_amt;
    logic                hazard;
    logic                fire;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] set_mask;

    assign imm8_ext = {24'b0, held_instr[7:0]};
    assign rot_amt  = {held_instr[11:8], 1'b0};

    always_comb begin
        aluOp            = 4'b0000;
        useImm           = 1'b0;
        imm              = 32'b0;
        isLoad           = 1'b0;
        isStore          = 1'b0;
        isBranch         = 1'b0;
        readReg1         = held_instr[19:16];
        readReg2         = held_instr[3:0];
        writeDestination = held_instr[15:12];
        writes           = 1'b0;
        use_rn           = 1'b0;
        use_rm           = 1'b0;
        case (held_instr[27:26])
            2'b00: begin
                aluOp  = held_instr[24:21];
                // TST/TEQ/CMP/CMN only set flags; MOV/MVN ignore Rn
                writes = (held_instr[24:23] != 2'b10);
                use_rn = !((held_instr[24:21] == 4'b1101) || (held_instr[24:21] == 4'b1111));
                if (held_instr[25]) begin
                    useImm = 1'b1;
                    imm    = (imm8_ext >> rot_amt) | (imm8_ext << (6'd32 - {1'b0, rot_amt}));
                end else begin
                    use_rm = 1'b1;
                end
            end
            2'b01: begin
                use_rn = 1'b1;
                useImm = 1'b1;
                imm    = {20'b0, held_instr[11:0]};
                aluOp  = held_instr[23] ? 4'b0100 : 4'b0010;
                if (held_instr[20]) begin
                    isLoad = 1'b1;
                    writes = 1'b1;
                end else begin
                    isStore  = 1'b1;
                    readReg2 = held_instr[15:12];
                    use_rm   = 1'b1;
                end
            end
            2'b10: begin
                isBranch = 1'b1;
                imm      = {{6{held_instr[23]}}, held_instr[23:0], 2'b00};
                if (held_instr[24]) begin
                    writes           = 1'b1;
                    writeDestination = 4'd14;
                end
            end
            default: ;
        endcase
    end

    // Hazard looks only at the registered mask, so a writeback releases the stall one cycle later
    assign hazard      = held_valid && ((use_rn && pending[readReg1]) ||
                                        (use_rm && pending[readReg2]) ||
                                        (writes && pending[writeDestination]));
    assign stall       = hazard;
    assign issueValid  = held_valid && !hazard && !flush;
    assign fire        = issueValid && issueReady;
    assign instrReady  = !held_valid || fire || flush;
    assign writeEnable = held_valid && writes;
    assign condCode    = held_instr[31:28];
    assign pcOut       = held_pc;

    assign clr_mask = wbEnable ? (NUM_REGS'(1) << wbDest) : '0;
    assign set_mask = (fire && writeEnable) ? (NUM_REGS'(1) << writeDestination) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            held_valid <= 1'b0;
            held_instr <= 32'b0;
            held_pc    <= 32'b0;
            pending    <= '0;
        end else begin
            if (instrValid && instrReady) begin
                held_valid <= 1'b1;
                held_instr <= instrIn;
                held_pc    <= pcIn;
            end else if (fire || flush) begin
                held_valid <= 1'b0;
            end
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

endmodule
